// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous address range on the registered read
// port of a simple dual-port RAM and streams the words out over valid/ready
// with a last marker. A 3-entry FIFO absorbs the 1-cycle read latency, so a
// consumer holding ready high receives one word per cycle.
// Optional feature: define RAM_STREAM_READER_ABORT_EN to add the abort input.
module ram_stream_reader #(
    parameter int addrLen = 6,
    parameter int dataLen = 32,
    parameter int memSize = 1 << addrLen
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [addrLen-1:0] base_addr,
    input  logic [addrLen:0]   len,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [addrLen-1:0] ram_addr,
    output logic               ram_re,
    input  logic [dataLen-1:0] ram_q,
    output logic [dataLen-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int                 CW        = addrLen + 1;
    localparam logic [addrLen-1:0] ADDR_LAST = addrLen'(memSize - 1);

    state_t             state_q, state_d;
    logic [addrLen-1:0] addr_q, addr_d;
    logic [CW-1:0]      issue_q, issue_d;
    logic [CW-1:0]      recv_q, recv_d;
    logic               inflight_q, inflight_d;
    logic               done_q, done_d;
    logic [1:0]         count_q, count_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [dataLen-1:0] fifo_q [0:2];

    logic push;
    logic pop;
    logic flush;
    logic credit_ok;
    logic abort_hit;

    // FIFO pointers wrap at the third entry.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Addresses wrap modulo the RAM depth.
    function automatic logic [addrLen-1:0] addr_inc(input logic [addrLen-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Outputs and read credit: a read is issued only when the FIFO is sure to
    // have room for it, counting the word already on its way from the RAM.
    always_comb begin
        credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
        ram_re    = (state_q == ISSUE) && (issue_q != '0) && credit_ok;
        ram_addr  = addr_q;
        m_valid   = (count_q != 2'd0);
        m_data    = m_valid ? fifo_q[rd_ptr_q] : '0;
        m_last    = m_valid && (recv_q == CW'(1));
        busy      = (state_q != IDLE);
        done      = done_q;
        push      = inflight_q;
        pop       = m_valid && m_ready;
    end

    // Next-state logic for the FSM, counters and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issue_d    = issue_q;
        recv_d     = recv_q;
        done_d     = 1'b0;
        inflight_d = ram_re;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        flush      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d  = base_addr;
                        issue_d = len;
                        recv_d  = len;
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ram_re) begin
                    addr_d  = addr_inc(addr_q);
                    issue_d = issue_q - 1'b1;
                    if (issue_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Each consumed word retires one from the burst; the final one ends it.
        if ((state_q != IDLE) && pop) begin
            recv_d = recv_q - 1'b1;
            if (recv_q == CW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort wins over everything else, including a same-cycle handshake.
        if (abort_hit) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            inflight_d = 1'b0;
            flush      = 1'b1;
        end

        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            issue_q    <= '0;
            recv_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            recv_q     <= recv_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage captures the RAM word the cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= ram_q;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural registered-read RAM.
module tb_ram_stream_reader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef RAM_STREAM_READER_ABORT_EN
    logic          abort;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ram_stream_reader #(.addrLen(AW), .dataLen(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_q     (ram_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    // Registered read port B of the RAM.
    always @(posedge clk) begin
        if (ram_re) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks all outputs of one cycle; address only when a read is expected,
    // data only when a word is expected.
    task automatic cyc(input string tag, input logic eb, input logic ere, input int ea,
                       input logic ev, input int ed, input logic el, input logic edn);
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".ram_re"}, 32'(ram_re), 32'(ere));
        if (ere) chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(ea));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
        if (ev) chk({tag, ".m_data"}, m_data, 32'(ed));
        chk({tag, ".m_last"}, 32'(m_last), 32'(el));
        chk({tag, ".done"}, 32'(done), 32'(edn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int b, input int l);
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Hand tables for the stalled len=8 burst once ready rises (cycles 7..14).
    int t2_re   [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    int t2_addr [8] = '{0, 3, 4, 5, 6, 7, 0, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i + 100);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
`ifdef RAM_STREAM_READER_ABORT_EN
        abort     = 1'b0;
`endif
        #2;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.ram_addr", 32'(ram_addr), 32'd0);
        chk("reset.m_data", m_data, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Burst 1: base 0, len 4, ready held high.
        m_ready = 1'b1;
        go(0, 4);
        cyc("b1c1", 1, 1, 0, 0, 0, 0, 0);   tick();
        cyc("b1c2", 1, 1, 1, 0, 0, 0, 0);   tick();
        cyc("b1c3", 1, 1, 2, 1, 100, 0, 0); tick();
        cyc("b1c4", 1, 1, 3, 1, 101, 0, 0); tick();
        cyc("b1c5", 1, 0, 0, 1, 102, 0, 0); tick();
        cyc("b1c6", 1, 0, 0, 1, 103, 1, 0); tick();
        cyc("b1c7", 0, 0, 0, 0, 0, 0, 1);

        // Burst 3 started in the done cycle: wraps 62,63,0,1.
        go(62, 4);
        cyc("b3c1", 1, 1, 62, 0, 0, 0, 0);  tick();
        cyc("b3c2", 1, 1, 63, 0, 0, 0, 0);  tick();
        cyc("b3c3", 1, 1, 0, 1, 162, 0, 0); tick();
        cyc("b3c4", 1, 1, 1, 1, 163, 0, 0); tick();
        cyc("b3c5", 1, 0, 0, 1, 100, 0, 0); tick();
        cyc("b3c6", 1, 0, 0, 1, 101, 1, 0); tick();
        cyc("b3c7", 0, 0, 0, 0, 0, 0, 1);   tick();
        cyc("b3c8", 0, 0, 0, 0, 0, 0, 0);

        // Burst 2: len 8 with ready low for the first six cycles.
        m_ready = 1'b0;
        go(0, 8);
        cyc("b2c1", 1, 1, 0, 0, 0, 0, 0);   tick();
        cyc("b2c2", 1, 1, 1, 0, 0, 0, 0);   tick();
        cyc("b2c3", 1, 1, 2, 1, 100, 0, 0); tick();
        cyc("b2c4", 1, 0, 0, 1, 100, 0, 0); tick();
        cyc("b2c5", 1, 0, 0, 1, 100, 0, 0); tick();
        cyc("b2c6", 1, 0, 0, 1, 100, 0, 0); tick();
        m_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cyc($sformatf("b2c%0d", j + 7), 1, t2_re[j] != 0, t2_addr[j], 1, 100 + j, j == 7, 0);
            tick();
        end
        cyc("b2c15", 0, 0, 0, 0, 0, 0, 1);  tick();

        // Zero-length start: done pulse only.
        go(5, 0);
        cyc("z1", 0, 0, 0, 0, 0, 0, 1); tick();
        cyc("z2", 0, 0, 0, 0, 0, 0, 0); tick();
        cyc("z3", 0, 0, 0, 0, 0, 0, 0);

        // Start pulsed mid-burst is ignored.
        go(20, 6);
        cyc("s1", 1, 1, 20, 0, 0, 0, 0); tick();
        base_addr = AW'(40);
        len       = (AW+1)'(3);
        start     = 1'b1;
        cyc("s2", 1, 1, 21, 0, 0, 0, 0); tick();
        start     = 1'b0;
        cyc("s3", 1, 1, 22, 1, 120, 0, 0); tick();
        cyc("s4", 1, 1, 23, 1, 121, 0, 0); tick();
        cyc("s5", 1, 1, 24, 1, 122, 0, 0); tick();
        cyc("s6", 1, 1, 25, 1, 123, 0, 0); tick();
        cyc("s7", 1, 0, 0, 1, 124, 0, 0);  tick();
        cyc("s8", 1, 0, 0, 1, 125, 1, 0);  tick();
        cyc("s9", 0, 0, 0, 0, 0, 0, 1);    tick();
        cyc("s10", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled burst.
        m_ready = 1'b0;
        go(0, 8);
        tick(); tick(); tick();
        cyc("r_pre", 1, 0, 0, 1, 100, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        cyc("r_mid", 0, 0, 0, 0, 0, 0, 0);
        chk("r_mid.ram_addr", 32'(ram_addr), 32'd0);
        chk("r_mid.m_data", m_data, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        cyc("r_idle", 0, 0, 0, 0, 0, 0, 0);

        // Fresh burst after reset.
        m_ready = 1'b1;
        go(10, 2);
        cyc("p1", 1, 1, 10, 0, 0, 0, 0);  tick();
        cyc("p2", 1, 1, 11, 0, 0, 0, 0);  tick();
        cyc("p3", 1, 0, 0, 1, 110, 0, 0); tick();
        cyc("p4", 1, 0, 0, 1, 111, 1, 0); tick();
        cyc("p5", 0, 0, 0, 0, 0, 0, 1);   tick();

`ifdef RAM_STREAM_READER_ABORT_EN
        // Abort after five handshakes of a 16-word burst.
        go(0, 16);
        cyc("a1", 1, 1, 0, 0, 0, 0, 0); tick();
        cyc("a2", 1, 1, 1, 0, 0, 0, 0); tick();
        for (int j = 0; j < 5; j++) begin
            cyc($sformatf("a%0d", j + 3), 1, 1, j + 2, 1, 100 + j, 0, 0);
            tick();
        end
        abort = 1'b1;
        cyc("a8", 1, 1, 7, 1, 105, 0, 0); tick();
        abort = 1'b0;
        cyc("a9", 0, 0, 0, 0, 0, 0, 1);  tick();
        cyc("a10", 0, 0, 0, 0, 0, 0, 0); tick();
        cyc("a11", 0, 0, 0, 0, 0, 0, 0);
        go(10, 2);
        cyc("q1", 1, 1, 10, 0, 0, 0, 0);  tick();
        cyc("q2", 1, 1, 11, 0, 0, 0, 0);  tick();
        cyc("q3", 1, 0, 0, 1, 110, 0, 0); tick();
        cyc("q4", 1, 0, 0, 1, 111, 1, 0); tick();
        cyc("q5", 0, 0, 0, 0, 0, 0, 1);   tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for a simple dual-port RAM (write port A, registered read port B with read-enable, 1-cycle read latency).
- On a start command, walks a contiguous address range on port B and presents the words as a valid/ready stream with a last marker.
- Hides the RAM read latency behind a 3-entry output FIFO, so a downstream consumer with backpressure gets 1 word/cycle sustained with no loss.

Parameters:
- addrLen, 6, RAM address width
- dataLen, 32, RAM/stream data width
- memSize, 1 << addrLen, RAM depth; addresses wrap modulo memSize

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start-burst pulse; sampled only when idle
- base_addr  in  addrLen  first read address, latched on accepted start
- len  in  addrLen+1  word count, 0..memSize, latched on accepted start
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- ram_addr  out  addrLen  RAM port B address
- ram_re  out  1  RAM port B read enable
- ram_q  in  dataLen  RAM port B registered read data
- m_data  out  dataLen  stream data (FIFO head)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  marks final word of burst

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; busy, done, ram_re, m_valid, m_last=0; ram_addr=0; m_data=0; FIFO count=0; in-flight flag cleared; counters=0. Takes effect immediately, mid-burst included. Any read in flight is discarded.
- FSM states IDLE, ISSUE, DRAIN.
  - IDLE + start + len!=0: latch base/len; issue counter=len, receive counter=len; busy=1 next cycle; go to ISSUE.
  - IDLE + start + len==0: done=1 for the next cycle only; no RAM read; stay IDLE; busy stays 0.
  - start while busy: ignored; no latch.
- ISSUE:
  - ram_re=1 in a cycle iff issue counter!=0 and (FIFO count + in-flight) < 3. Uses registered state only; no combinational path from m_ready to ram_re.
  - Each issued read drives ram_addr=current address; address then increments modulo memSize (63 -> 0 for addrLen=6); issue counter decrements.
  - Issue counter reaching 0 -> DRAIN.
- Read pipeline:
  - ram_re high in cycle k: ram_q valid in cycle k+1, written to the FIFO at the end of k+1.
  - m_valid first asserts in cycle k+2.
  - Minimum latency from accepted start to first m_valid is 3 cycles.
- Stream:
  - m_valid = (FIFO count != 0); m_data = head.
  - Handshake when m_valid && m_ready. On handshake: pop, and receive counter decrements.
  - m_data/m_valid/m_last must hold stable while m_valid && !m_ready.
  - FIFO push and pop in the same cycle: allowed, count unchanged.
  - Overflow is impossible by the credit rule; verification asserts count<=3.
- m_last: asserted with the head word when it is the final word of the burst (receive counter==1 and head is the last entry).
- DRAIN: on the handshake of the last word, done=1 next cycle, busy=0 in that same cycle, FSM to IDLE.
  - A start in the done cycle is accepted.
  - busy is high from the cycle after the accepted start through the cycle of the final handshake.
- Full throughput: with m_ready held 1, one ram_re per cycle and one handshake per cycle in steady state.

Optional Feature:
- Macro: RAM_STREAM_READER_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 while busy: the next edge stops issuing, empties the FIFO, and drops the in-flight read (ram_q ignored next cycle).
  - m_valid=0 from the next cycle; done pulses the next cycle; busy=0; FSM to IDLE.
  - abort while idle has no effect.
  - abort takes priority over a same-cycle handshake (that word counts as consumed).
- Not defined: no abort port; every accepted burst runs to completion.

Test Plan:
- mem[i]=i+100, base=0, len=4, m_ready=1 -> ram_re for 4 consecutive cycles on addresses 0..3. m_data 100,101,102,103 on consecutive cycles starting 3 cycles after start. m_last only with 103. done pulses one cycle after the 103 handshake.
- Same burst with len=8, m_ready=0 for 6 cycles then 1 -> exactly 3 reads issued, then ram_re=0 until a pop. Output 100..107 in order, no duplicates or drops. m_data stable while stalled.
- addrLen=6, base=62, len=4 -> ram_addr sequence 62,63,0,1; data mem[62],mem[63],mem[0],mem[1].
- len=0 start -> done pulse next cycle; ram_re and m_valid never assert; busy stays 0.
- start pulsed mid-burst -> ignored, burst unaffected. Then rst_n=0 mid-burst -> all outputs 0 immediately. A new burst after reset (base=10, len=2) returns mem[10],mem[11] correctly.
- ABORT_EN: len=16, abort after 5 handshakes -> m_valid=0 the next cycle, done pulse, no further ram_re. The following burst returns correct data.
